// File: rtl/ram16k_arbiter.sv
// Two-port arbiter in front of a single RAM16k, with a bulk-clear engine.
// Every RAM port is driven from a flop; one access takes IDLE -> ACCESS -> ACK.
module ram16k_arbiter #(
  parameter logic [15:0] FILL_VALUE = 16'h0000,
  parameter int          DEPTH      = 16384
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        r0_req,
  input  logic        r0_we,
  input  logic [13:0] r0_addr,
  input  logic [15:0] r0_wdata,
  output logic        r0_ack,
  output logic [15:0] r0_rdata,
  input  logic        r1_req,
  input  logic        r1_we,
  input  logic [13:0] r1_addr,
  input  logic [15:0] r1_wdata,
  output logic        r1_ack,
  output logic [15:0] r1_rdata,
  input  logic        clr_start,
  output logic        clr_busy,
  output logic [15:0] ram_in,
  output logic [13:0] ram_addr,
  output logic        ram_load,
  input  logic [15:0] ram_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK, CLEAR} state_t;

  localparam logic [13:0] LAST_ADDR = 14'(DEPTH - 1);

  state_t      state_q, state_d;
  logic        r0_ack_q, r0_ack_d, r1_ack_q, r1_ack_d;
  logic [15:0] r0_rdata_q, r0_rdata_d, r1_rdata_q, r1_rdata_d;
  logic [15:0] ram_in_q, ram_in_d;
  logic [13:0] ram_addr_q, ram_addr_d;
  logic        ram_load_q, ram_load_d;
  logic        clr_pending_q, clr_pending_d;
  logic [13:0] cnt_q, cnt_d;
  logic        last_grant_q, last_grant_d;
  logic        grant_q, grant_d;
  logic        pick;

  always_comb begin
    state_d       = state_q;
    r0_ack_d      = 1'b0;
    r1_ack_d      = 1'b0;
    r0_rdata_d    = r0_rdata_q;
    r1_rdata_d    = r1_rdata_q;
    ram_in_d      = ram_in_q;
    ram_addr_d    = ram_addr_q;
    ram_load_d    = ram_load_q;
    cnt_d         = cnt_q;
    last_grant_d  = last_grant_q;
    grant_d       = grant_q;
    clr_pending_d = clr_pending_q | (clr_start && (state_q != CLEAR));
    pick          = (r0_req && r1_req) ? ~last_grant_q : r1_req;

    case (state_q)
      IDLE: begin
        if (clr_pending_q) begin
          state_d       = CLEAR;
          clr_pending_d = 1'b0;
          cnt_d         = '0;
          ram_addr_d    = '0;
          ram_in_d      = FILL_VALUE;
          ram_load_d    = 1'b1;
        end else if (r0_req || r1_req) begin
          state_d    = ACCESS;
          grant_d    = pick;
          ram_addr_d = pick ? r1_addr  : r0_addr;
          ram_in_d   = pick ? r1_wdata : r0_wdata;
          ram_load_d = pick ? r1_we    : r0_we;
          if (r0_req && r1_req) last_grant_d = pick;
        end
      end
      ACCESS: begin
        // ram_load_q still reflects the latched write enable here
        if (!ram_load_q) begin
          if (grant_q) r1_rdata_d = ram_out;
          else         r0_rdata_d = ram_out;
        end
        r0_ack_d   = ~grant_q;
        r1_ack_d   = grant_q;
        ram_load_d = 1'b0;
        state_d    = ACK;
      end
      ACK: state_d = IDLE;
      CLEAR: begin
        if (cnt_q == LAST_ADDR) begin
          state_d    = IDLE;
          ram_load_d = 1'b0;
        end else begin
          cnt_d      = cnt_q + 14'd1;
          ram_addr_d = cnt_q + 14'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      r0_ack_q      <= 1'b0;
      r1_ack_q      <= 1'b0;
      r0_rdata_q    <= '0;
      r1_rdata_q    <= '0;
      ram_in_q      <= '0;
      ram_addr_q    <= '0;
      ram_load_q    <= 1'b0;
      clr_pending_q <= 1'b0;
      cnt_q         <= '0;
      last_grant_q  <= 1'b1;
      grant_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      r0_ack_q      <= r0_ack_d;
      r1_ack_q      <= r1_ack_d;
      r0_rdata_q    <= r0_rdata_d;
      r1_rdata_q    <= r1_rdata_d;
      ram_in_q      <= ram_in_d;
      ram_addr_q    <= ram_addr_d;
      ram_load_q    <= ram_load_d;
      clr_pending_q <= clr_pending_d;
      cnt_q         <= cnt_d;
      last_grant_q  <= last_grant_d;
      grant_q       <= grant_d;
    end
  end

  assign r0_ack   = r0_ack_q;
  assign r1_ack   = r1_ack_q;
  assign r0_rdata = r0_rdata_q;
  assign r1_rdata = r1_rdata_q;
  assign ram_in   = ram_in_q;
  assign ram_addr = ram_addr_q;
  assign ram_load = ram_load_q;
  assign clr_busy = clr_pending_q | (state_q == CLEAR);

endmodule

// File: tb/tb_ram16k_arbiter.sv
// Directed bench for ram16k_arbiter: vector table of single transactions plus
// hand-written contention, clear and mid-sweep reset sequences against a RAM model.
module tb_ram16k_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        r0_req, r0_we, r1_req, r1_we;
  logic [13:0] r0_addr, r1_addr;
  logic [15:0] r0_wdata, r1_wdata;
  logic        r0_ack, r1_ack;
  logic [15:0] r0_rdata, r1_rdata;
  logic        clr_start, clr_busy;
  logic [15:0] ram_in, ram_out;
  logic [13:0] ram_addr;
  logic        ram_load;
  logic        fill_mem;

  int passCount = 0;
  int totalCount = 0;

  typedef struct {
    bit          port;
    bit          we;
    logic [13:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_r0;
    logic [15:0] exp_r1;
  } vec_t;

  vec_t vecs [8];
  logic [15:0] mem [16384];

  ram16k_arbiter dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ack(r0_ack), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ack(r1_ack), .r1_rdata(r1_rdata),
    .clr_start(clr_start), .clr_busy(clr_busy),
    .ram_in(ram_in), .ram_addr(ram_addr), .ram_load(ram_load), .ram_out(ram_out)
  );

  always #5 clk = ~clk;

  // RAM16k model: synchronous write, combinational read, preloaded with a marker
  always @(posedge clk) begin
    if (fill_mem) begin
      for (int i = 0; i < 16384; i++) mem[i] <= 16'hdead;
    end else if (ram_load) begin
      mem[ram_addr] <= ram_in;
    end
  end
  assign ram_out = mem[ram_addr];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic doTxn(input bit port, input bit we, input logic [13:0] addr,
                       input logic [15:0] wdata, output int lat, output int loads);
    bit done;
    if (!port) begin
      r0_we = we; r0_addr = addr; r0_wdata = wdata; r0_req = 1'b1;
    end else begin
      r1_we = we; r1_addr = addr; r1_wdata = wdata; r1_req = 1'b1;
    end
    lat = 0; loads = 0; done = 1'b0;
    while (!done && lat < 50) begin
      @(negedge clk);
      lat++;
      loads += int'(ram_load);
      done = port ? r1_ack : r0_ack;
    end
    r0_req = 1'b0;
    r1_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    int lat, loads;
    doTxn(v.port, v.we, v.addr, v.wdata, lat, loads);
    checkOutput($sformatf("vec%0d_latency", idx), lat, 2);
    checkOutput($sformatf("vec%0d_load_cycles", idx), loads, int'(v.we));
    checkOutput($sformatf("vec%0d_r0_rdata", idx), r0_rdata, v.exp_r0);
    checkOutput($sformatf("vec%0d_r1_rdata", idx), r1_rdata, v.exp_r1);
  endtask

  task automatic doReset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int lat, loads, busyCnt, loadCnt, addrErr, sweep, wait_n, fall_n, earlyAck, order;
    int ackAt [4];
    bit both;

    reset = 1'b1; fill_mem = 1'b1;
    r0_req = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0;
    r1_req = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0;
    clr_start = 0;

    vecs[0] = '{1'b0, 1'b1, 14'h3324, 16'habcd, 16'h0000, 16'h0000};
    vecs[1] = '{1'b0, 1'b0, 14'h3324, 16'h0000, 16'habcd, 16'h0000};
    vecs[2] = '{1'b1, 1'b1, 14'h0001, 16'h1234, 16'habcd, 16'h0000};
    vecs[3] = '{1'b0, 1'b0, 14'h0001, 16'h0000, 16'h1234, 16'h0000};
    vecs[4] = '{1'b1, 1'b0, 14'h3324, 16'h0000, 16'h1234, 16'habcd};
    vecs[5] = '{1'b1, 1'b1, 14'h3fff, 16'h0f0f, 16'h1234, 16'habcd};
    vecs[6] = '{1'b0, 1'b0, 14'h3fff, 16'h0000, 16'h0f0f, 16'habcd};
    vecs[7] = '{1'b0, 1'b0, 14'h0002, 16'h0000, 16'hdead, 16'habcd};

    @(negedge clk);
    fill_mem = 1'b0;
    doReset();

    checkOutput("reset_r0_ack", r0_ack, 0);
    checkOutput("reset_r1_ack", r1_ack, 0);
    checkOutput("reset_r0_rdata", r0_rdata, 0);
    checkOutput("reset_r1_rdata", r1_rdata, 0);
    checkOutput("reset_ram_load", ram_load, 0);
    checkOutput("reset_ram_addr", ram_addr, 0);
    checkOutput("reset_ram_in", ram_in, 0);
    checkOutput("reset_clr_busy", clr_busy, 0);

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i], i);

    // Sustained contention from reset: R0,R1,R0,R1 with acks 3 cycles apart
    doReset();
    r0_we = 0; r0_addr = 14'h3324; r1_we = 0; r1_addr = 14'h0001;
    r0_req = 1'b1; r1_req = 1'b1;
    both = 1'b0; order = 0; ackAt = '{0, 0, 0, 0};
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (r0_ack && r1_ack) both = 1'b1;
      if ((r0_ack || r1_ack) && order < 4) begin
        ackAt[order] = k * 2 + int'(r1_ack);
        order++;
      end
    end
    r0_req = 1'b0; r1_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("contend_both_acks", both, 0);
    checkOutput("contend_ack0", ackAt[0], 4);
    checkOutput("contend_ack1", ackAt[1], 11);
    checkOutput("contend_ack2", ackAt[2], 16);
    checkOutput("contend_ack3", ackAt[3], 23);
    checkOutput("contend_r0_rdata", r0_rdata, 16'habcd);
    checkOutput("contend_r1_rdata", r1_rdata, 16'h1234);

    // Full clear sweep
    doTxn(1'b0, 1'b1, 14'h3f00, 16'hffff, lat, loads);
    checkOutput("clr_prewrite_latency", lat, 2);
    clr_start = 1'b1;
    @(negedge clk);
    clr_start = 1'b0;
    busyCnt = 0; loadCnt = 0; addrErr = 0; sweep = 0;
    while (clr_busy && busyCnt < 20000) begin
      busyCnt++;
      if (ram_load) begin
        loadCnt++;
        if (ram_addr !== 14'(sweep)) addrErr++;
        if (ram_in !== 16'h0000) addrErr++;
        sweep++;
      end
      @(negedge clk);
    end
    checkOutput("clr_busy_cycles", busyCnt, 16385);
    checkOutput("clr_load_cycles", loadCnt, 16384);
    checkOutput("clr_sweep_errors", addrErr, 0);
    doTxn(1'b0, 1'b0, 14'h3f00, 16'h0000, lat, loads);
    checkOutput("clr_read_3f00", r0_rdata, 16'h0000);
    doTxn(1'b1, 1'b0, 14'h0000, 16'h0000, lat, loads);
    checkOutput("clr_read_0000", r1_rdata, 16'h0000);

    // clr_start during R0 ACCESS, R1 arriving mid-CLEAR
    doTxn(1'b1, 1'b1, 14'h0001, 16'h5555, lat, loads);
    doTxn(1'b1, 1'b0, 14'h0001, 16'h0000, lat, loads);
    checkOutput("mid_r1_pre_rdata", r1_rdata, 16'h5555);
    r0_we = 0; r0_addr = 14'h0001; r0_req = 1'b1;
    @(negedge clk);
    clr_start = 1'b1;
    @(negedge clk);
    clr_start = 1'b0;
    checkOutput("mid_r0_ack", r0_ack, 1);
    checkOutput("mid_busy_pending", clr_busy, 1);
    r0_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("mid_clear_started", ram_load, 1);
    r1_we = 0; r1_addr = 14'h0001; r1_req = 1'b1;
    wait_n = 0; fall_n = -1; earlyAck = 0;
    while (!r1_ack && wait_n < 20000) begin
      @(negedge clk);
      wait_n++;
      if (r1_ack && clr_busy) earlyAck++;
      if (!clr_busy && fall_n < 0) fall_n = wait_n;
    end
    r1_req = 1'b0;
    @(negedge clk);
    checkOutput("mid_r1_early_ack", earlyAck, 0);
    checkOutput("mid_r1_ack_after_busy", wait_n - fall_n, 2);
    checkOutput("mid_r1_rdata", r1_rdata, 16'h0000);

    // Reset in the middle of a sweep
    clr_start = 1'b1;
    @(negedge clk);
    clr_start = 1'b0;
    wait_n = 0;
    while (!(ram_load && ram_addr == 14'd100) && wait_n < 300) begin
      @(negedge clk);
      wait_n++;
    end
    checkOutput("rst_reached_cnt100", int'(ram_load && ram_addr == 14'd100), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rst_ram_load", ram_load, 0);
    checkOutput("rst_clr_busy", clr_busy, 0);
    checkOutput("rst_acks", {r0_ack, r1_ack}, 0);
    r0_we = 0; r0_addr = 14'h0200; r1_we = 0; r1_addr = 14'h0300;
    r0_req = 1'b1; r1_req = 1'b1;
    loadCnt = 0;
    @(negedge clk);
    loadCnt += int'(ram_load);
    @(negedge clk);
    loadCnt += int'(ram_load);
    checkOutput("rst_first_tie_acks", {r0_ack, r1_ack}, 2'b10);
    checkOutput("rst_no_resumed_sweep", loadCnt, 0);
    r0_req = 1'b0; r1_req = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
